// File: rtl/imm_gen_pkg.sv
// Shared definitions for the pipelined immediate generator.
//   FMT_*  : immediate format codes presented on out_fmt.
//   OPC_*  : RV32/RV64 major opcodes recognised by the decoder.
// The result record (imm_res_t) depends on the XLEN/TAG_W parameters of the
// instantiating module, so it is declared there rather than here.
package imm_gen_pkg;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_32  = 7'b0111011;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe.
//   flush                     : discard all buffered entries
//   in_valid/in_ready         : instruction input channel (in_instr, in_tag)
//   out_valid/out_ready       : result output channel (out_imm, out_fmt, out_illegal, out_tag)
// master = producer/consumer side (drives inputs), slave = imm_gen_pipe.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush, in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  flush, in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder.
//   instr_i   : 32-bit instruction word
//   imm_o     : immediate, sign-extended from instr_i[31] to XLEN
//   fmt_o     : FMT_* format code
//   illegal_o : opcode not recognised (R-type is legal with FMT_NONE)
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  logic [31:0] imm32;
  logic        sgn;

  assign sgn = instr_i[31];

  always_comb begin
    imm32     = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    case (instr_i[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
        imm32 = {{20{sgn}}, instr_i[31:20]};
        fmt_o = FMT_I;
      end
      OPC_STORE: begin
        imm32 = {{20{sgn}}, instr_i[31:25], instr_i[11:7]};
        fmt_o = FMT_S;
      end
      OPC_BRANCH: begin
        imm32 = {{19{sgn}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        fmt_o = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32 = {instr_i[31:12], 12'b0};
        fmt_o = FMT_U;
      end
      OPC_JAL: begin
        imm32 = {{11{sgn}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        fmt_o = FMT_J;
      end
      OPC_OP:    illegal_o = 1'b0;
      // OP-32 only exists on RV64.
      OPC_OP_32: illegal_o = (XLEN != 64);
      default:   illegal_o = 1'b1;
    endcase
  end

  // Every 32-bit immediate is already sign-correct; widen by replicating bit 31.
  if (XLEN > 32) begin : g_sext
    assign imm_o = {{(XLEN-32){imm32[31]}}, imm32};
  end else begin : g_nosext
    assign imm_o = imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes the incoming instruction and stores
// only the decoded result in a 2-entry skid buffer (main + skid).
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : imm_gen_pipe_if.slave (flush, in_* channel, out_* channel)
// Outputs are driven straight from the main entry; in_ready depends only on
// buffer state and rst, never on out_ready.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input logic          clk,
  input logic          rst,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } imm_res_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e   state_q, state_d;
  imm_res_t main_q, main_d;
  imm_res_t skid_q, skid_d;
  imm_res_t dec_res;
  logic     in_ready;
  logic     out_valid;
  logic     accept;
  logic     pop;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr_i  (bus.in_instr),
    .imm_o    (dec_res.imm),
    .fmt_o    (dec_res.fmt),
    .illegal_o(dec_res.illegal)
  );
  assign dec_res.tag = bus.in_tag;

  assign in_ready  = (state_q != StTwo) && !rst;
  assign out_valid = (state_q != StEmpty);
  // Flush wins over accept, so an instruction offered alongside flush is dropped.
  assign accept    = bus.in_valid && in_ready && !bus.flush;
  assign pop       = out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = dec_res;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            main_d = dec_res;
          end else if (accept) begin
            skid_d  = dec_res;
            state_d = StTwo;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_illegal = main_q.illegal;
  assign bus.out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance
// share one stimulus stream and are compared every cycle against a
// queue-based FIFO model with an arithmetic immediate reference.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_tag;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

  assign bus32.flush     = flush;
  assign bus32.in_valid  = in_valid;
  assign bus32.in_instr  = in_instr;
  assign bus32.in_tag    = in_tag;
  assign bus32.out_ready = out_ready;
  assign bus64.flush     = flush;
  assign bus64.in_valid  = in_valid;
  assign bus64.in_instr  = in_instr;
  assign bus64.in_tag    = in_tag;
  assign bus64.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference decode (arithmetic, not bit-concatenation) ----
  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } ref_t;

  function automatic ref_t ref_dec(input logic [31:0] ins, input bit is64);
    ref_t   r;
    longint v;
    int     op;
    r.imm = '0; r.fmt = 3'd0; r.illegal = 1'b0;
    v  = 0;
    op = int'(ins[6:0]);
    case (op)
      'h03, 'h13, 'h67, 'h73: begin
        r.fmt = 3'd1;
        v = longint'(ins[31:20]);
        if (ins[31]) v -= 4096;
      end
      'h23: begin
        r.fmt = 3'd2;
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (ins[31]) v -= 4096;
      end
      'h63: begin
        r.fmt = 3'd3;
        v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (ins[31]) v -= 4096;
      end
      'h37, 'h17: begin
        r.fmt = 3'd4;
        v = longint'(ins[31:12]) * 4096;
        if (ins[31]) v -= 64'sh1_0000_0000;
      end
      'h6F: begin
        r.fmt = 3'd5;
        v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (ins[31]) v -= 1048576;
      end
      'h33: r.illegal = 1'b0;
      'h3B: r.illegal = !is64;
      default: r.illegal = 1'b1;
    endcase
    r.imm = 64'(v);
    return r;
  endfunction

  // ---------------- FIFO model --------------------------------------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] tag;
  } ent_t;

  ent_t q[$];
  ent_t disp;          // entry currently shown on out_* (held after pop/flush)
  bit   disp_rst = 1'b1;
  bit   armed    = 1'b0;

  always @(posedge clk) begin : model
    int   sz;
    ent_t e;
    if (rst) begin
      q.delete();
      disp_rst = 1'b1;
      armed    = 1'b1;
    end else if (armed) begin
      sz = q.size();
      if (flush) begin
        q.delete();
      end else begin
        if (sz > 0 && out_ready) void'(q.pop_front());
        if (in_valid && sz < 2) begin
          e.instr = in_instr;
          e.tag   = in_tag;
          q.push_back(e);
        end
      end
      if (q.size() > 0) begin
        disp     = q[0];
        disp_rst = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    ref_t        r32, r64;
    logic [31:0] etag;
    if (armed) begin
      check("out_valid32", 64'(bus32.out_valid), 64'(q.size() > 0));
      check("out_valid64", 64'(bus64.out_valid), 64'(q.size() > 0));
      check("in_ready32", 64'(bus32.in_ready), 64'(q.size() < 2 && !rst));
      check("in_ready64", 64'(bus64.in_ready), 64'(q.size() < 2 && !rst));
      if (disp_rst) begin
        r32.imm = '0; r32.fmt = 3'd0; r32.illegal = 1'b0;
        r64 = r32;
        etag = '0;
      end else begin
        r32  = ref_dec(disp.instr, 1'b0);
        r64  = ref_dec(disp.instr, 1'b1);
        etag = disp.tag;
      end
      check("out_imm32", 64'(bus32.out_imm), 64'(r32.imm[31:0]));
      check("out_fmt32", 64'(bus32.out_fmt), 64'(r32.fmt));
      check("out_illegal32", 64'(bus32.out_illegal), 64'(r32.illegal));
      check("out_tag32", 64'(bus32.out_tag), 64'(etag));
      check("out_imm64", bus64.out_imm, r64.imm);
      check("out_fmt64", 64'(bus64.out_fmt), 64'(r64.fmt));
      check("out_illegal64", 64'(bus64.out_illegal), 64'(r64.illegal));
      check("out_tag64", 64'(bus64.out_tag), 64'(etag));
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int tagc = 100;

  task automatic apply(input string nm, input logic [31:0] ins, input logic [31:0] e32,
                       input logic [63:0] e64, input logic [2:0] efmt, input bit eill);
    ref_t pin;
    pin = ref_dec(ins, 1'b1);
    check({nm, "_model"}, pin.imm, e64);
    in_valid = 1'b1; in_instr = ins; in_tag = 32'(tagc); out_ready = 1'b1;
    tagc++;
    step();
    in_valid = 1'b0;
    check({nm, "_valid"}, 64'(bus32.out_valid), 64'd1);
    check({nm, "_imm32"}, 64'(bus32.out_imm), 64'(e32));
    check({nm, "_imm64"}, bus64.out_imm, e64);
    check({nm, "_fmt"}, 64'(bus32.out_fmt), 64'(efmt));
    check({nm, "_illegal"}, 64'(bus32.out_illegal), 64'(eill));
    step();
  endtask

  logic [6:0] opc_tab [14] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
                               7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h00, 7'h0B};

  initial begin
    logic [31:0] rnd;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_tag = '0;
    step();
    step();
    check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus32.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(bus32.in_ready), 64'd1);
    step();

    // Known encodings with hand-computed immediates.
    apply("addi", 32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    apply("sw",   32'h00112623, 32'h0000000C, 64'h000000000000000C, 3'd2, 1'b0);
    apply("beq",  32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0);
    apply("lui",  32'h123452B7, 32'h12345000, 64'h0000000012345000, 3'd4, 1'b0);
    apply("jal",  32'h0010006F, 32'h00000800, 64'h0000000000000800, 3'd5, 1'b0);
    apply("ill",  32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b1);
    apply("lui64", 32'h800002B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0);

    // Backpressure: tags 1,2 accepted, 3 held, then drained in order.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_tag = 32'd1;
    step();
    check("bp_tag1", 64'(bus32.out_tag), 64'd1);
    check("bp_ready1", 64'(bus32.in_ready), 64'd1);
    in_tag = 32'd2;
    step();
    check("bp_ready2", 64'(bus32.in_ready), 64'd0);
    in_tag = 32'd3;
    step();
    check("bp_hold", 64'(bus32.out_tag), 64'd1);
    out_ready = 1'b1;
    step();
    check("bp_tag2", 64'(bus32.out_tag), 64'd2);
    step();
    in_valid = 1'b0;
    check("bp_tag3", 64'(bus32.out_tag), 64'd3);
    step();
    check("bp_empty", 64'(bus32.out_valid), 64'd0);

    // Flush in ONE and in TWO with an instruction offered alongside.
    for (int k = 1; k <= 2; k++) begin
      out_ready = 1'b0; in_valid = 1'b1;
      for (int j = 0; j < k; j++) begin
        in_tag = 32'(20 + 10 * k + j);
        step();
      end
      in_tag = 32'(29 + 10 * k);
      flush  = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_valid", 64'(bus32.out_valid), 64'd0);
      check("flush_ready", 64'(bus32.in_ready), 64'd1);
      out_ready = 1'b1;
      step();
      check("flush_gone", 64'(bus32.out_valid), 64'd0);
    end

    // Reset mid-stream.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFE000CE3; in_tag = 32'd40;
    step();
    in_tag = 32'd41;
    step();
    rst = 1'b1;
    step();
    check("mrst_valid", 64'(bus32.out_valid), 64'd0);
    check("mrst_imm", 64'(bus32.out_imm), 64'd0);
    check("mrst_tag", 64'(bus32.out_tag), 64'd0);
    check("mrst_fmt", 64'(bus32.out_fmt), 64'd0);
    check("mrst_ready", 64'(bus32.in_ready), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    step();

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      rnd       = $urandom();
      in_instr  = {rnd[31:7], opc_tab[$urandom_range(0, 13)]};
      in_tag    = $urandom();
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 3);
      rst       = ($urandom_range(0, 199) < 1);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
